// File: rtl/memory_addr_generator_if.sv
// Interface bundling the request, address and burst signals of
// memory_addr_generator.
//   master : drives unit_id/vector_index/matrix_row/matrix_col, addr_req,
//            burst_start/burst_mode/burst_step; observes all addresses.
//   slave  : the generator; drives vector_addr/matrix_addr, the registered
//            copies with addr_valid, and burst_addr/burst_active/burst_last.
interface memory_addr_generator_if #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned VEC_LEN   = 16,
  parameter int unsigned MAT_DIM   = 16
);
  localparam int unsigned UW = $clog2(NUM_UNITS);
  localparam int unsigned VW = $clog2(VEC_LEN);
  localparam int unsigned MW = $clog2(MAT_DIM);
  localparam int unsigned VA = UW + VW;
  localparam int unsigned MA = 2 * MW;

  logic [UW-1:0] unit_id;
  logic [VW-1:0] vector_index;
  logic [MW-1:0] matrix_row;
  logic [MW-1:0] matrix_col;
  logic [VA-1:0] vector_addr;
  logic [MA-1:0] matrix_addr;
  logic          addr_req;
  logic [VA-1:0] vector_addr_q;
  logic [MA-1:0] matrix_addr_q;
  logic          addr_valid;
  logic          burst_start;
  logic          burst_mode;
  logic          burst_step;
  logic [MA-1:0] burst_addr;
  logic          burst_active;
  logic          burst_last;

  modport master (
    output unit_id, vector_index, matrix_row, matrix_col,
    output addr_req, burst_start, burst_mode, burst_step,
    input  vector_addr, matrix_addr, vector_addr_q, matrix_addr_q, addr_valid,
    input  burst_addr, burst_active, burst_last
  );

  modport slave (
    input  unit_id, vector_index, matrix_row, matrix_col,
    input  addr_req, burst_start, burst_mode, burst_step,
    output vector_addr, matrix_addr, vector_addr_q, matrix_addr_q, addr_valid,
    output burst_addr, burst_active, burst_last
  );
endinterface

// File: rtl/memory_addr_generator.sv
// Address generator between the shared-memory controller and the
// vector/matrix memories.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset.
//   bus        : slave side of memory_addr_generator_if.
//     - vector_addr/matrix_addr : combinational {unit,index} / {row,col}.
//     - vector_addr_q/matrix_addr_q/addr_valid : one-cycle registered copy
//       captured on addr_req.
//     - burst_* : 16-step stepper walking a unit vector (mode 0) or a
//       matrix row (mode 1).
module memory_addr_generator #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned VEC_LEN   = 16,
  parameter int unsigned MAT_DIM   = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  memory_addr_generator_if.slave bus
);
  localparam int unsigned UW = $clog2(NUM_UNITS);
  localparam int unsigned VW = $clog2(VEC_LEN);
  localparam int unsigned MW = $clog2(MAT_DIM);
  localparam int unsigned VA = UW + VW;
  localparam int unsigned MA = 2 * MW;

  typedef enum logic {IDLE, ACTIVE} burst_state_t;

  // Combinational mapping.
  assign bus.vector_addr = {bus.unit_id, bus.vector_index};
  assign bus.matrix_addr = {bus.matrix_row, bus.matrix_col};

  // Registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vector_addr_q <= '0;
      bus.matrix_addr_q <= '0;
      bus.addr_valid    <= 1'b0;
    end else begin
      bus.addr_valid <= bus.addr_req;
      if (bus.addr_req) begin
        bus.vector_addr_q <= bus.vector_addr;
        bus.matrix_addr_q <= bus.matrix_addr;
      end
    end
  end

  // Burst stepper.
  burst_state_t  state_q, state_d;
  logic [VW-1:0] count_q, count_d;
  logic          mode_q, mode_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [MW-1:0] row_q, row_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= 1'b0;
      unit_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      unit_q  <= unit_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    unit_d  = unit_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        // burst_step is deliberately not looked at here, so a step that
        // coincides with burst_start cannot skip the first address.
        if (bus.burst_start) begin
          state_d = ACTIVE;
          count_d = '0;
          mode_d  = bus.burst_mode;
          unit_d  = bus.unit_id;
          row_d   = bus.matrix_row;
        end
      end
      ACTIVE: begin
        if (bus.burst_step) begin
          if (count_q == '1) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.burst_addr   = '0;
    bus.burst_active = 1'b0;
    bus.burst_last   = 1'b0;
    if (state_q == ACTIVE) begin
      bus.burst_active = 1'b1;
      bus.burst_last   = (count_q == '1);
      if (mode_q)
        bus.burst_addr = {row_q, count_q};
      else
        bus.burst_addr[VA-1:0] = {unit_q, count_q};
    end
  end
endmodule

// File: tb/tb_memory_addr_generator.sv
module tb_memory_addr_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_addr_generator_if bus ();

  memory_addr_generator #(
    .NUM_UNITS(4),
    .VEC_LEN  (16),
    .MAT_DIM  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic expect_val(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_burst(input string tag, input logic [7:0] addr,
                           input logic act, input logic last);
    expect_val({tag, "_addr"}, addr);
    expect_val({tag, "_active"}, {7'b0, act});
    expect_val({tag, "_last"}, {7'b0, last});
    chk(bus.burst_addr);
    chk({7'b0, bus.burst_active});
    chk({7'b0, bus.burst_last});
  endtask

  initial begin
    bus.unit_id = '0; bus.vector_index = '0; bus.matrix_row = '0;
    bus.matrix_col = '0; bus.addr_req = 1'b0; bus.burst_start = 1'b0;
    bus.burst_mode = 1'b0; bus.burst_step = 1'b0;

    // Reset state
    #2;
    expect_val("rst_vq", 8'h00);     chk(8'(bus.vector_addr_q));
    expect_val("rst_mq", 8'h00);     chk(bus.matrix_addr_q);
    expect_val("rst_valid", 8'h00);  chk({7'b0, bus.addr_valid});
    chk_burst("rst", 8'h00, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // Combinational mapping
    bus.unit_id = 2'd2; bus.vector_index = 4'd5;
    bus.matrix_row = 4'd3; bus.matrix_col = 4'd10;
    #1;
    expect_val("comb_va", 8'h25); chk(8'(bus.vector_addr));
    expect_val("comb_ma", 8'h3A); chk(bus.matrix_addr);
    for (int u = 0; u < 4; u++) begin
      bus.unit_id = 2'(u);
      #1;
      expect_val($sformatf("comb_va_u%0d", u), 8'(u * 16 + 5));
      chk(8'(bus.vector_addr));
      expect_val($sformatf("comb_ma_u%0d", u), 8'h3A);
      chk(bus.matrix_addr);
    end
    bus.unit_id = 2'd3; bus.vector_index = 4'd15;
    bus.matrix_row = 4'd15; bus.matrix_col = 4'd15;
    #1;
    expect_val("max_va", 8'h3F); chk(8'(bus.vector_addr));
    expect_val("max_ma", 8'hFF); chk(bus.matrix_addr);
    bus.unit_id = '0; bus.vector_index = '0;
    bus.matrix_row = '0; bus.matrix_col = '0;
    #1;
    expect_val("zero_va", 8'h00); chk(8'(bus.vector_addr));
    expect_val("zero_ma", 8'h00); chk(bus.matrix_addr);

    // Registered stage
    tick();
    bus.unit_id = 2'd1; bus.vector_index = 4'd7;
    bus.matrix_row = 4'd4; bus.matrix_col = 4'd2; bus.addr_req = 1'b1;
    tick();
    bus.addr_req = 1'b0;
    bus.unit_id = 2'd3; bus.vector_index = 4'd0; bus.matrix_row = 4'd8;
    expect_val("req_vq", 8'h17);    chk(8'(bus.vector_addr_q));
    expect_val("req_mq", 8'h42);    chk(bus.matrix_addr_q);
    expect_val("req_valid", 8'h01); chk({7'b0, bus.addr_valid});
    tick();
    expect_val("hold_vq", 8'h17);    chk(8'(bus.vector_addr_q));
    expect_val("hold_mq", 8'h42);    chk(bus.matrix_addr_q);
    expect_val("hold_valid", 8'h00); chk({7'b0, bus.addr_valid});
    // back-to-back
    bus.addr_req = 1'b1; bus.unit_id = 2'd2; bus.vector_index = 4'd9;
    tick();
    expect_val("b2b0_vq", 8'h29);    chk(8'(bus.vector_addr_q));
    expect_val("b2b0_valid", 8'h01); chk({7'b0, bus.addr_valid});
    bus.unit_id = 2'd0; bus.vector_index = 4'd3;
    tick();
    bus.addr_req = 1'b0;
    expect_val("b2b1_vq", 8'h03);    chk(8'(bus.vector_addr_q));
    expect_val("b2b1_valid", 8'h01); chk({7'b0, bus.addr_valid});
    tick();
    expect_val("b2b2_valid", 8'h00); chk({7'b0, bus.addr_valid});

    // Burst mode 0, unit 3
    bus.unit_id = 2'd3; bus.burst_mode = 1'b0; bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0; bus.unit_id = 2'd0; bus.burst_step = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_burst($sformatf("v%0d", i), 8'(8'h30 + i), 1'b1, i == 15);
      tick();
    end
    bus.burst_step = 1'b0;
    chk_burst("v_done", 8'h00, 1'b0, 1'b0);

    // Burst mode 1, row 9, step with start
    bus.matrix_row = 4'd9; bus.burst_mode = 1'b1;
    bus.burst_start = 1'b1; bus.burst_step = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    chk_burst("m0", 8'h90, 1'b1, 1'b0);
    tick();
    bus.burst_step = 1'b0;
    chk_burst("m1", 8'h91, 1'b1, 1'b0);
    bus.burst_start = 1'b1; bus.matrix_row = 4'd5; bus.burst_mode = 1'b0;
    tick();
    bus.burst_start = 1'b0;
    chk_burst("m_restart", 8'h91, 1'b1, 1'b0);
    bus.burst_step = 1'b1;
    for (int i = 2; i < 16; i++) begin
      tick();
      if (i == 15) chk_burst("m15", 8'h9F, 1'b1, 1'b1);
    end
    tick();
    bus.burst_step = 1'b0;
    chk_burst("m_done", 8'h00, 1'b0, 1'b0);

    // Reset mid-burst at count 6
    bus.matrix_row = 4'd2; bus.burst_mode = 1'b1; bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0; bus.burst_step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.addr_req = 1'b1;
      tick();
    end
    bus.burst_step = 1'b0; bus.addr_req = 1'b0;
    chk_burst("pre_rst", 8'h26, 1'b1, 1'b0);
    expect_val("pre_rst_valid", 8'h01); chk({7'b0, bus.addr_valid});
    rst_n = 1'b0;
    #1;
    chk_burst("mid_rst", 8'h00, 1'b0, 1'b0);
    expect_val("mid_rst_valid", 8'h00); chk({7'b0, bus.addr_valid});
    expect_val("mid_rst_vq", 8'h00);    chk(8'(bus.vector_addr_q));
    bus.unit_id = 2'd1; bus.vector_index = 4'd4;
    #1;
    expect_val("rst_comb_va", 8'h14);   chk(8'(bus.vector_addr));
    tick();
    rst_n = 1'b1;
    bus.burst_mode = 1'b0; bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0; bus.burst_step = 1'b1;
    chk_burst("post_rst0", 8'h10, 1'b1, 1'b0);
    tick();
    bus.burst_step = 1'b0;
    chk_burst("post_rst1", 8'h11, 1'b1, 1'b0);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_addr_generator.md
Name: memory_addr_generator

Overview:
- Address generator between the shared-memory controller and the vector/matrix memories.
- Combinational path maps a unit's request to a vector-memory address (64 entries, 4 units × 16 elements) and a matrix-memory address (shared 16×16 matrix, 256 × 2-bit entries).
- Also provides a registered copy of that mapping with a valid strobe.
- Also provides a 16-step burst stepper for walking a vector or a matrix row.

Parameters:
- NUM_UNITS, 4, number of requesting units; unit_id width = log2(NUM_UNITS) = 2.
- VEC_LEN, 16, elements per unit vector; index width 4.
- MAT_DIM, 16, matrix rows = columns; row/col width 4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- unit_id  input  2  requesting unit.
- vector_index  input  4  element index within the unit's vector.
- matrix_row  input  4  matrix row index.
- matrix_col  input  4  matrix column index.
- vector_addr  output  6  combinational vector-memory address.
- matrix_addr  output  8  combinational matrix-memory address.
- addr_req  input  1  capture request for the registered stage.
- vector_addr_q  output  6  registered vector address.
- matrix_addr_q  output  8  registered matrix address.
- addr_valid  output  1  registered addresses updated this cycle.
- burst_start  input  1  start a 16-step burst.
- burst_mode  input  1  0 = vector walk, 1 = matrix-row walk.
- burst_step  input  1  advance burst by one address.
- burst_addr  output  8  current burst address (vector addr zero-extended in mode 0).
- burst_active  output  1  burst in progress.
- burst_last  output  1  burst_addr is the 16th address.

Behaviour:
- Combinational mapping, no clock, no reset dependency:
  - vector_addr = {unit_id, vector_index}.
  - matrix_addr = {matrix_row, matrix_col}, independent of unit_id.
  - Pure concatenation; all index combinations legal; no wrap or saturation needed.
- Registered stage:
  - On a rising edge with addr_req=1: vector_addr_q/matrix_addr_q load the combinational values; addr_valid<=1.
  - With addr_req=0: the _q outputs hold; addr_valid<=0.
  - Latency is 1 cycle; back-to-back requests each produce one valid cycle.
- Burst stepper states: IDLE, ACTIVE.
- IDLE:
  - burst_start=1 latches burst_mode, unit_id and matrix_row; clears the 4-bit count; goes to ACTIVE.
  - burst_step is ignored in IDLE, including the same cycle as burst_start.
- ACTIVE:
  - burst_addr = {2'b00, unit_l, count} in mode 0, or {row_l, count} in mode 1.
  - burst_last = (count == 15).
  - burst_step=1 with count<15: count increments by 1.
  - burst_step=1 with count==15: return to IDLE; count clears.
  - burst_step=0: hold.
  - burst_start while ACTIVE is ignored; latched values do not change.
- IDLE outputs: burst_addr=0, burst_active=0, burst_last=0.
- burst_active=1 exactly in ACTIVE; all burst outputs are registered-state decodes.
- Reset (async assert, any time including mid-burst): vector_addr_q=0, matrix_addr_q=0, addr_valid=0, state=IDLE, count=0, latched fields=0. Combinational outputs remain driven from inputs during reset.
- Input changes during ACTIVE do not affect burst_addr.

Test Plan:
- unit_id=2, vector_index=5, matrix_row=3, matrix_col=10 -> vector_addr=0x25, matrix_addr=0x3A in the same cycle; repeat with unit_id=0..3 -> matrix_addr unchanged.
- Extremes: unit_id=3, vector_index=15, row=15, col=15 -> vector_addr=0x3F, matrix_addr=0xFF; all zeros -> 0x00/0x00.
- addr_req pulse 1 cycle with unit_id=1, vector_index=7 -> next cycle vector_addr_q=0x17, addr_valid=1 for one cycle; the _q outputs hold after inputs change.
- burst_start, mode 0, unit_id=3, then 16 burst_step -> burst_addr 0x30..0x3F; burst_last only at 0x3F; burst_active drops after the 16th step.
- burst_start, mode 1, row=9 together with burst_step in the same cycle -> count starts at 0 (burst_addr=0x90); a second burst_start mid-burst is ignored; step sequence reaches 0x9F.
- Assert rst_n=0 at count=6 mid-burst -> burst_active=0, burst_addr=0, addr_valid=0 immediately; after release a new burst starts cleanly from count 0.
